// File: rtl/intr_ctrl.sv
// 8-source edge-triggered interrupt controller with IDLE/REQ/ACK CPU handshake and memory-mapped registers.
// Optional periodic timer on PEND[0] is built when INTC_TIMER_EN is defined.
module intr_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_in,
    output logic        intr,
    input  logic        int_ack,
    input  logic        dm_cs,
    input  logic        dm_wr,
    input  logic        dm_rd,
    input  logic [11:0] Addr,
    input  logic [31:0] D_In,
    output logic [31:0] D_Out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  vec_q, vec_d;
    logic [7:0]  irq_s_q, irq_s_d;
    logic [7:0]  irq_p_q, irq_p_d;
    logic        armed_q, armed_d;
    logic [31:0] dout_q, dout_d;

    logic [9:0]  word;
    logic        wr_en, rd_en;
    logic [7:0]  edge_set, w1c_clr, ack_clr, pm;
    logic [2:0]  lo;
    logic        tmr_tick;
    logic [31:0] rdata;
    logic        unused;

    assign word   = Addr[11:2];
    assign wr_en  = dm_cs & dm_wr;
    assign rd_en  = dm_cs & dm_rd & ~dm_wr;
    assign pm     = pend_q & mask_q;
    assign unused = ^{D_In[31:8], Addr[1:0]};

    // The first sample after reset seeds the previous-sample register, so a level already high is not an edge.
    always_comb begin
        irq_s_d  = irq_in;
        irq_p_d  = armed_q ? irq_s_q : irq_in;
        armed_d  = 1'b1;
        edge_set = irq_s_q & ~irq_p_q;
    end

    always_comb begin
        lo = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pm[i]) lo = 3'(i);
        end
    end

`ifdef INTC_TIMER_EN
    logic [31:0] tload_q, tload_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        wr_tl;

    assign wr_tl = wr_en && (word == 10'd4);

    // Reload period is TIMER_LOAD+1 cycles; a zero load value parks the counter.
    always_comb begin
        tload_d  = wr_tl ? D_In : tload_q;
        tmr_tick = (tload_q != 32'd0) && (tcnt_q == 32'd0);
        if (wr_tl)
            tcnt_d = D_In;
        else if (tload_q == 32'd0)
            tcnt_d = tcnt_q;
        else if (tcnt_q == 32'd0)
            tcnt_d = tload_q;
        else
            tcnt_d = tcnt_q - 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tload_q <= 32'd0;
            tcnt_q  <= 32'd0;
        end else begin
            tload_q <= tload_d;
            tcnt_q  <= tcnt_d;
        end
    end
`else
    assign tmr_tick = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_clr = 8'h00;
        case (state_q)
            S_IDLE: if (pm != 8'h00) state_d = S_REQ;
            S_REQ: begin
                if (pm == 8'h00) begin
                    state_d = S_IDLE;
                end else if (int_ack) begin
                    state_d = S_ACK;
                    vec_d   = lo;
                    ack_clr = 8'h01 << lo;
                end
            end
            S_ACK:   if (!int_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A new edge in the same cycle as a clear wins, so the set term is ORed in last.
    always_comb begin
        w1c_clr = (wr_en && (word == 10'd0)) ? D_In[7:0] : 8'h00;
        mask_d  = (wr_en && (word == 10'd1)) ? D_In[7:0] : mask_q;
        pend_d  = (pend_q & ~(w1c_clr | ack_clr)) | edge_set | {7'b0, tmr_tick};
    end

    always_comb begin
        rdata = 32'd0;
        case (word)
            10'd0: rdata = {24'd0, pend_q};
            10'd1: rdata = {24'd0, mask_q};
            10'd2: rdata = {29'd0, vec_q};
            10'd3: rdata = {30'd0, (state_q == S_ACK), (state_q == S_REQ)};
`ifdef INTC_TIMER_EN
            10'd4: rdata = tload_q;
`endif
            default: rdata = 32'd0;
        endcase
        dout_d = rd_en ? rdata : dout_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= 8'h00;
            mask_q  <= 8'h00;
            vec_q   <= 3'd0;
            irq_s_q <= 8'h00;
            irq_p_q <= 8'h00;
            armed_q <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            irq_s_q <= irq_s_d;
            irq_p_q <= irq_p_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
        end
    end

    assign intr  = (state_q == S_REQ);
    assign D_Out = dout_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed handshake scenarios plus randomized traffic against a behavioural model.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        intr;
    logic        int_ack;
    logic        dm_cs, dm_wr, dm_rd;
    logic [11:0] Addr;
    logic [31:0] D_In;
    logic [31:0] D_Out;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: raw irq history, pending set, and a waiting/serviced handshake view.
    logic [7:0]  m_pend, m_mask;
    logic [2:0]  m_vec;
    bit          m_wait, m_serv;
    logic [31:0] m_dout;
    logic [7:0]  m_hist[$];
    longint      m_tl, m_tw;
    int          m_n;

    intr_ctrl dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .intr(intr), .int_ack(int_ack),
        .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd), .Addr(Addr), .D_In(D_In), .D_Out(D_Out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic m_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_vec = 3'd0;
        m_wait = 0; m_serv = 0; m_dout = 32'd0;
        m_hist.delete();
        m_tl = 0; m_tw = 0; m_n = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a[11:2])
            10'd0: return {24'd0, m_pend};
            10'd1: return {24'd0, m_mask};
            10'd2: return {29'd0, m_vec};
            10'd3: return {30'd0, m_serv, m_wait};
`ifdef INTC_TIMER_EN
            10'd4: return m_tl[31:0];
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        logic [7:0] set_b, clr_b, pm;
        int lo;
        if (reset !== 1'b1) return;
        set_b = (m_hist.size() >= 2) ? (m_hist[0] & ~m_hist[1]) : 8'h00;
`ifdef INTC_TIMER_EN
        if (m_tl != 0 && m_n > m_tw && ((m_n - m_tw) % (m_tl + 1)) == 0) set_b[0] = 1'b1;
`endif
        clr_b = 8'h00;
        if (dm_cs && dm_rd && !dm_wr) m_dout = m_read(Addr);
        pm = m_pend & m_mask;
        if (m_wait) begin
            if (pm == 8'h00) m_wait = 0;
            else if (int_ack) begin
                lo = 0;
                for (int i = 0; i < 8; i++) if (pm[i]) begin lo = i; break; end
                m_vec = lo[2:0];
                clr_b[lo] = 1'b1;
                m_wait = 0;
                m_serv = 1;
            end
        end else if (m_serv) begin
            if (!int_ack) m_serv = 0;
        end else if (pm != 8'h00) begin
            m_wait = 1;
        end
        if (dm_cs && dm_wr) begin
            case (Addr[11:2])
                10'd0: clr_b = clr_b | D_In[7:0];
                10'd1: m_mask = D_In[7:0];
                10'd4: begin
`ifdef INTC_TIMER_EN
                    m_tl = D_In;
                    m_tw = m_n;
`endif
                end
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr_b) | set_b;
        m_hist.push_front(irq_in);
        if (m_hist.size() > 2) void'(m_hist.pop_back());
        m_n++;
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        dm_cs = 1; dm_rd = 1; dm_wr = 0; Addr = a;
        cycle();
        d = D_Out;
        dm_cs = 0; dm_rd = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        dm_cs = 1; dm_wr = 1; dm_rd = 0; Addr = a; D_In = v;
        cycle();
        dm_cs = 0; dm_wr = 0;
    endtask

    task automatic apply_reset();
        reset = 0;
        m_reset();
        repeat (2) cycle();
        reset = 1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 0; irq_in = 8'h00; int_ack = 0; dm_cs = 0; dm_wr = 0; dm_rd = 0;
        Addr = 12'h0; D_In = 32'h0;
        m_reset();
        repeat (3) cycle();
        n_total++; if (intr !== 1'b0) $display("FAIL reset_intr got %b want 0", intr); else n_pass++;
        n_total++; if (D_Out !== 32'd0) $display("FAIL reset_dout got %h want 0", D_Out); else n_pass++;
        reset = 1;
        for (int a = 0; a < 5; a++) begin
            rd(12'(a * 4), d);
            n_total++;
            if (d !== 32'd0) $display("FAIL reset_reg%0d got %h want 0", a, d); else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        wr(12'h004, 32'hFF);
        irq_in = 8'h08; cycle();
        irq_in = 8'h00; cycle();
        rd(12'h000, d);
        n_total++; if (d !== 32'h08) $display("FAIL single_pend got %h want 08", d); else n_pass++;
        n_total++; if (intr !== 1'b1) $display("FAIL single_intr got %b want 1", intr); else n_pass++;
        int_ack = 1; cycle();
        n_total++; if (intr !== 1'b0) $display("FAIL single_intr_drop got %b want 0", intr); else n_pass++;
        rd(12'h00C, d);
        n_total++; if (d !== 32'h2) $display("FAIL single_status got %h want 2", d); else n_pass++;
        int_ack = 0;
        rd(12'h008, d);
        n_total++; if (d !== 32'h3) $display("FAIL single_vec got %h want 3", d); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h0) $display("FAIL single_pend_clr got %h want 0", d); else n_pass++;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        irq_in = 8'h24; cycle();
        cycle();
        cycle();
        n_total++; if (intr !== 1'b1) $display("FAIL prio_intr1 got %b want 1", intr); else n_pass++;
        int_ack = 1; cycle();
        int_ack = 0;
        rd(12'h008, d);
        n_total++; if (d !== 32'h2) $display("FAIL prio_vec1 got %h want 2", d); else n_pass++;
        cycle();
        n_total++; if (intr !== 1'b1) $display("FAIL prio_intr2 got %b want 1", intr); else n_pass++;
        int_ack = 1; cycle();
        int_ack = 0; cycle();
        rd(12'h008, d);
        n_total++; if (d !== 32'h5) $display("FAIL prio_vec2 got %h want 5", d); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h0) $display("FAIL prio_pend got %h want 0", d); else n_pass++;
        irq_in = 8'h00;
    endtask

    task automatic test_mask();
        logic [31:0] d;
        wr(12'h004, 32'h00);
        irq_in = 8'h02; cycle();
        cycle();
        cycle();
        n_total++; if (intr !== 1'b0) $display("FAIL mask_intr_off got %b want 0", intr); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h02) $display("FAIL mask_pend got %h want 02", d); else n_pass++;
        wr(12'h004, 32'h02);
        cycle();
        n_total++; if (intr !== 1'b1) $display("FAIL mask_intr_on got %b want 1", intr); else n_pass++;
        int_ack = 1; cycle();
        int_ack = 0; cycle();
        irq_in = 8'h00;
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        wr(12'h004, 32'hFF);
        irq_in = 8'h10; cycle();
        irq_in = 8'h00; cycle();
        cycle();
        n_total++; if (intr !== 1'b1) $display("FAIL w1c_req got %b want 1", intr); else n_pass++;
        wr(12'h000, 32'h10);
        cycle();
        n_total++; if (intr !== 1'b0) $display("FAIL w1c_idle got %b want 0", intr); else n_pass++;
        rd(12'h008, d);
        n_total++; if (d !== 32'h1) $display("FAIL w1c_vec got %h want 1", d); else n_pass++;
        irq_in = 8'h10; cycle();
        irq_in = 8'h00;
        wr(12'h000, 32'h10);
        rd(12'h000, d);
        n_total++; if (d !== 32'h10) $display("FAIL w1c_race_pend got %h want 10", d); else n_pass++;
        n_total++; if (intr !== 1'b1) $display("FAIL w1c_race_req got %b want 1", intr); else n_pass++;
        int_ack = 1; cycle();
        int_ack = 0; cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(12'h004, 32'hFF);
        irq_in = 8'hFF; cycle();
        cycle();
        cycle();
        n_total++; if (intr !== 1'b1) $display("FAIL rstmid_req got %b want 1", intr); else n_pass++;
        reset = 0;
        #1;
        n_total++; if (intr !== 1'b0) $display("FAIL rstmid_async got %b want 0", intr); else n_pass++;
        m_reset();
        repeat (2) cycle();
        n_total++; if (D_Out !== 32'd0) $display("FAIL rstmid_dout got %h want 0", D_Out); else n_pass++;
        reset = 1;
        repeat (4) cycle();
        rd(12'h004, d);
        n_total++; if (d !== 32'h0) $display("FAIL rstmid_mask got %h want 0", d); else n_pass++;
        wr(12'h004, 32'hFF);
        cycle();
        cycle();
        n_total++; if (intr !== 1'b0) $display("FAIL rstmid_noedge got %b want 0", intr); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h0) $display("FAIL rstmid_pend got %h want 0", d); else n_pass++;
        rd(12'h008, d);
        n_total++; if (d !== 32'h0) $display("FAIL rstmid_vec got %h want 0", d); else n_pass++;
        irq_in = 8'h00;
    endtask

    task automatic test_rw_both();
        logic [31:0] d;
        rd(12'h004, d);
        n_total++; if (d !== 32'hFF) $display("FAIL rw_pre got %h want ff", d); else n_pass++;
        dm_cs = 1; dm_wr = 1; dm_rd = 1; Addr = 12'h004; D_In = 32'h5A;
        cycle();
        dm_cs = 0; dm_wr = 0; dm_rd = 0;
        n_total++; if (D_Out !== 32'hFF) $display("FAIL rw_hold got %h want ff", D_Out); else n_pass++;
        rd(12'h004, d);
        n_total++; if (d !== 32'h5A) $display("FAIL rw_written got %h want 5a", d); else n_pass++;
        wr(12'h100, 32'hFFFF_FFFF);
        rd(12'h100, d);
        n_total++; if (d !== 32'h0) $display("FAIL rw_unmapped got %h want 0", d); else n_pass++;
    endtask

    task automatic test_timer();
        logic [31:0] d;
        apply_reset();
`ifdef INTC_TIMER_EN
        wr(12'h004, 32'h01);
        wr(12'h010, 32'd5);
        repeat (5) cycle();
        rd(12'h000, d);
        n_total++; if (d !== 32'h0) $display("FAIL tmr_early got %h want 0", d); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h1) $display("FAIL tmr_fire1 got %h want 1", d); else n_pass++;
        wr(12'h000, 32'h01);
        repeat (3) cycle();
        rd(12'h000, d);
        n_total++; if (d !== 32'h0) $display("FAIL tmr_gap got %h want 0", d); else n_pass++;
        rd(12'h000, d);
        n_total++; if (d !== 32'h1) $display("FAIL tmr_fire2 got %h want 1", d); else n_pass++;
        rd(12'h010, d);
        n_total++; if (d !== 32'd5) $display("FAIL tmr_load got %h want 5", d); else n_pass++;
        wr(12'h010, 32'd0);
`else
        wr(12'h010, 32'hFFFF_FFFF);
        rd(12'h010, d);
        n_total++; if (d !== 32'h0) $display("FAIL tmr_absent got %h want 0", d); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [11:0] tbl [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h100, 12'hFFC};
        logic [11:0] a;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            dm_cs = ($urandom_range(0, 3) == 0);
            dm_wr = 1'($urandom_range(0, 1));
            dm_rd = 1'($urandom_range(0, 1));
            a = tbl[$urandom_range(0, 7)] | 12'($urandom_range(0, 3));
            Addr = a;
            D_In = (a[11:2] == 10'd4) ? 32'($urandom_range(0, 9)) : $urandom;
            cycle();
            n_total++;
            if (intr !== m_wait) $display("FAIL rand_intr cyc %0d got %b want %b", c, intr, m_wait); else n_pass++;
            n_total++;
            if (D_Out !== m_dout) $display("FAIL rand_dout cyc %0d got %h want %h", c, D_Out, m_dout); else n_pass++;
        end
        dm_cs = 0; dm_wr = 0; dm_rd = 0; int_ack = 0; irq_in = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_w1c_race();
        test_reset_mid();
        test_rw_both();
        test_timer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 irq_in  input  8  external interrupt sources, level inputs, asynchronous to nothing (clk-domain).
REQ-004 intr  output  1  interrupt request to CPU.
REQ-005 int_ack  input  1  CPU acknowledge of intr.
REQ-006 dm_cs, dm_wr, dm_rd  input  1 each  register-access strobes, same semantics as data memory.
REQ-007 Addr  input  12  byte address of register, word-aligned (Addr[1:0] ignored).
REQ-008 D_In  input  32  write data.
REQ-009 D_Out  output  32  read data.

Function
REQ-010 Register map SHALL be: 0x000 PEND (RO, W1C), 0x004 MASK (RW, bits[7:0]), 0x008 VECTOR (RO, bits[2:0]), 0x00C STATUS (RO: bit0 = intr, bit1 = FSM in ACK), 0x010 TIMER_LOAD (see Configuration); other addresses read 0 and ignore writes.
REQ-011 Each irq_in bit SHALL be registered once; a 0->1 transition between consecutive registered samples sets PEND[i] in the following cycle.
REQ-012 Write to PEND with dm_cs&dm_wr SHALL clear every PEND bit whose D_In bit is 1.
REQ-013 Simultaneous set (edge) and clear (W1C or ack) of the same PEND bit SHALL leave it set.
REQ-014 FSM states IDLE, REQ, ACK; IDLE->REQ when (PEND & MASK) != 0.
REQ-015 In REQ, intr SHALL be 1; REQ->ACK on the first cycle int_ack=1.
REQ-016 On the REQ->ACK transition, VECTOR SHALL latch the lowest index i with PEND[i]&MASK[i]=1, and PEND[i] SHALL clear.
REQ-017 intr SHALL be 0 in IDLE and ACK; it deasserts the cycle after int_ack is sampled high.
REQ-018 ACK->IDLE when int_ack=0; a new request cannot issue until then.
REQ-019 If (PEND & MASK) becomes 0 while in REQ (mask write or W1C) before int_ack, FSM SHALL return to IDLE and VECTOR is unchanged.
REQ-020 Read: D_Out SHALL be registered, valid the cycle after dm_cs&dm_rd, and holds its value otherwise.
REQ-021 dm_wr and dm_rd both high with dm_cs SHALL perform the write only; D_Out unchanged.

Reset
REQ-022 While reset=0: PEND=0, MASK=0, VECTOR=0, irq sample register=0, FSM=IDLE, intr=0, D_Out=0, timer counter=0, TIMER_LOAD=0.
REQ-023 Reset asserted mid-handshake SHALL drop intr immediately (asynchronously); after release, irq_in already high SHALL NOT count as an edge.

Configuration
REQ-024 Macro INTC_TIMER_EN: when defined, TIMER_LOAD is a 32-bit RW register and a 32-bit down-counter reloads from it; on reaching 0 with TIMER_LOAD != 0 it sets PEND[0] (ORed with irq_in[0] edge) and reloads; TIMER_LOAD=0 stops the timer; writing TIMER_LOAD loads the counter the next cycle.
REQ-025 When INTC_TIMER_EN is undefined, no counter is built, 0x010 reads 0 and writes are ignored.

Verification
REQ-026 MASK=0xFF, pulse irq_in[3] high -> PEND=0x08 two cycles later, intr=1; int_ack=1 -> VECTOR=3, PEND=0x00, intr=0 next cycle.
REQ-027 irq_in[5] and irq_in[2] rise same cycle, MASK=0xFF -> first ack gives VECTOR=2; after int_ack low, second request, ack gives VECTOR=5.
REQ-028 MASK=0x00, irq_in[1] edge -> PEND=0x02, intr stays 0; write MASK=0x02 -> intr=1 next cycle.
REQ-029 In REQ with PEND=0x10, write PEND=0x10 (W1C) -> FSM to IDLE, intr=0, VECTOR unchanged; same-cycle new irq_in[4] edge -> PEND[4] stays 1.
REQ-030 Assert reset=0 while intr=1 and irq_in=0xFF -> intr=0 immediately, all registers 0; release -> no new PEND bits.
REQ-031 INTC_TIMER_EN defined, TIMER_LOAD=5, MASK=0x01 -> PEND[0] sets periodically every 6 cycles; undefined build -> read 0x010 returns 0x00000000.
